// File: rtl/pong_pkg.sv
// Shared types and screen constants for the pong datapath.
// Also holds the clamped edge-step helpers used by the paddle controller.
package pong_pkg;

  typedef logic [11:0] coord_t;

  typedef enum logic [1:0] {IDLE, SLOW, FAST} paddle_state_t;
  typedef enum logic [1:0] {NONE, UP, DN} dir_t;

  localparam int H_ACTIVE = 1920;
  localparam int V_ACTIVE = 1080;

  // Move an edge up by s, stopping at line 0.
  function automatic coord_t clamp_up(coord_t v, coord_t s);
    return (v >= s) ? coord_t'(v - s) : '0;
  endfunction

  // Move an edge down by s, stopping at vmax; 13-bit sum so wrap cannot fake a pass.
  function automatic coord_t clamp_dn(coord_t v, coord_t s, coord_t vmax);
    logic [12:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    return (sum <= {1'b0, vmax}) ? sum[11:0] : vmax;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-time debounce for one raw push-button.
// db follows the synchronised level only after DEBOUNCE_CYC consecutive mismatched cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1485000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      db      <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (sync_q2 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= sync_q2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: debounced up/down buttons move a fixed-height
// paddle once per frame, at the first vertical-blank line, with step escalation.
//
//   state | meaning
//   IDLE  | no direction held; paddle parked
//   SLOW  | moving STEP_SLOW px/frame, counting consecutive same-direction frames
//   FAST  | moving STEP_FAST px/frame until release or reversal
module paddle_ctrl #(
  parameter int RC_H1        = 100,
  parameter int RC_H2        = 200,
  parameter int RC_V1        = 0,
  parameter int RC_V2        = 250,
  parameter int V_ACTIVE     = pong_pkg::V_ACTIVE,
  parameter int DEBOUNCE_CYC = 1485000,
  parameter int STEP_SLOW    = 4,
  parameter int STEP_FAST    = 12,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic [11:0] h_count,
  input  logic [11:0] v_count,
  output logic        btn_up_db,
  output logic        btn_dn_db,
  output logic [11:0] current_rc_h1,
  output logic [11:0] current_rc_h2,
  output logic [11:0] current_rc_v1,
  output logic [11:0] current_rc_v2,
  output logic        fast
);

  import pong_pkg::*;

  if (!(RC_V1 >= 0 && RC_V1 < RC_V2 && RC_V2 <= V_ACTIVE - 1)) begin : g_bad_vert
    $error("paddle_ctrl: vertical reset edges outside visible area");
  end
  if (!(STEP_FAST >= STEP_SLOW && STEP_SLOW >= 1 && HOLD_FRAMES >= 1)) begin : g_bad_step
    $error("paddle_ctrl: illegal step or hold configuration");
  end

  localparam coord_t HEIGHT = coord_t'(RC_V2 - RC_V1);
  localparam coord_t V_MAX  = coord_t'(V_ACTIVE - 1);
  localparam coord_t STEP_S = coord_t'(STEP_SLOW);
  localparam coord_t STEP_F = coord_t'(STEP_FAST);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

  paddle_state_t state;
  dir_t          dir;
  dir_t          last_dir;
  logic [15:0]   hold;
  coord_t        v1;
  coord_t        v2;
  coord_t        step;
  coord_t        mv_v1;
  coord_t        mv_v2;
  logic          frame_tick;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk (clk), .rst (rst), .btn (btn_up), .db (btn_up_db)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk (clk), .rst (rst), .btn (btn_dn), .db (btn_dn_db)
  );

  always_comb begin
    frame_tick = (v_count == 12'(V_ACTIVE)) && (h_count == 12'd0);
    dir = NONE;
    if (btn_up_db && !btn_dn_db)      dir = UP;
    else if (btn_dn_db && !btn_up_db) dir = DN;
  end

  // Candidate position for this tick; the FSM decides whether to commit it.
  always_comb begin
    step  = (state == FAST) ? STEP_F : STEP_S;
    mv_v1 = v1;
    mv_v2 = v2;
    if (dir == UP) begin
      mv_v1 = clamp_up(v1, step);
      mv_v2 = mv_v1 + HEIGHT;
    end else if (dir == DN) begin
      mv_v2 = clamp_dn(v2, step, V_MAX);
      mv_v1 = mv_v2 - HEIGHT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_dir <= NONE;
      hold     <= '0;
      fast     <= 1'b0;
      v1       <= coord_t'(RC_V1);
      v2       <= coord_t'(RC_V2);
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (dir != NONE) begin
            state    <= SLOW;
            hold     <= '0;
            last_dir <= dir;
            v1       <= mv_v1;
            v2       <= mv_v2;
          end
        end
        SLOW: begin
          if (dir == NONE) begin
            state <= IDLE;
            hold  <= '0;
          end else if (dir != last_dir) begin
            hold     <= '0;
            last_dir <= dir;
            v1       <= mv_v1;
            v2       <= mv_v2;
          end else begin
            v1 <= mv_v1;
            v2 <= mv_v2;
            // >= keeps HOLD_FRAMES == 1 from never escalating
            if (hold + 16'd1 >= HOLD_LAST) begin
              state <= FAST;
              fast  <= 1'b1;
              hold  <= '0;
            end else begin
              hold <= hold + 16'd1;
            end
          end
        end
        FAST: begin
          if (dir == NONE || dir != last_dir) begin
            state <= IDLE;
            fast  <= 1'b0;
          end else begin
            v1 <= mv_v1;
            v2 <= mv_v2;
          end
        end
        default: begin
          state <= IDLE;
          fast  <= 1'b0;
        end
      endcase
    end
  end

  assign current_rc_h1 = 12'(RC_H1);
  assign current_rc_h2 = 12'(RC_H2);
  assign current_rc_v1 = v1;
  assign current_rc_v2 = v2;

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Turns one pair of raw Basys3 push-buttons into the live bounding box of one paddle.
- Sits directly upstream of the paddle renderer and of the ball/collision logic, and consumes the VGA controller's h_count/v_count.
- Synchronises and debounces both buttons, then moves the paddle vertically once per frame during vertical blank.
- Step size escalates while a direction is held, and the position is clamped to the visible area.

Parameters:
- RC_H1, 100: fixed left edge, px
- RC_H2, 200: fixed right edge, px
- RC_V1, 0: reset top edge, px
- RC_V2, 250: reset bottom edge, px; paddle height H = RC_V2 - RC_V1, constant
- V_ACTIVE, 1080: visible lines; bottom edge never exceeds V_ACTIVE-1
- DEBOUNCE_CYC, 1485000: stable cycles required to accept a button change (10 ms at 148.5 MHz)
- STEP_SLOW, 4: px per frame in SLOW
- STEP_FAST, 12: px per frame in FAST
- HOLD_FRAMES, 30: consecutive moving frames in SLOW before entering FAST

Ports:
- clk  in  1  pixel clock, 148.5 MHz domain
- rst  in  1  asynchronous, active-low reset
- btn_up  in  1  raw button, asynchronous to clk
- btn_dn  in  1  raw button, asynchronous to clk
- h_count  in  12  VGA horizontal counter
- v_count  in  12  VGA vertical counter
- btn_up_db  out  1  debounced level
- btn_dn_db  out  1  debounced level
- current_rc_h1  out  12  paddle left edge, always RC_H1
- current_rc_h2  out  12  paddle right edge, always RC_H2
- current_rc_v1  out  12  paddle top edge
- current_rc_v2  out  12  paddle bottom edge
- fast  out  1  high while the FSM is in FAST

Behaviour:
- Reset (async assert, sync deassert via the clock edge):
  - v1 = RC_V1, v2 = RC_V2, h1/h2 = params.
  - btn_*_db = 0, debounce counters = 0, synchronisers = 0.
  - FSM = IDLE, hold counter = 0, fast = 0.
- Synchroniser: 2-FF per button; raw-to-sync latency is 2 cycles.
- Debounce, per button:
  - If sync != db, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYC-1 while still mismatched, db <= sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYC cycles never reaches db.
- frame_tick (internal, 1 cycle): asserted when v_count == V_ACTIVE and h_count == 0, i.e. the first blank line. All position and FSM updates occur only on frame_tick, so there is no mid-frame tearing.
- dir:
  - UP = up_db & ~dn_db
  - DN = dn_db & ~up_db
  - NONE otherwise; both pressed counts as NONE and the paddle holds.
- FSM states, evaluated on frame_tick:
  - IDLE: dir != NONE -> SLOW, hold = 0, and that same tick moves by STEP_SLOW.
  - SLOW: dir == NONE -> IDLE. Direction differs from the last move -> stay SLOW, hold = 0. Otherwise hold++; when hold == HOLD_FRAMES-1 -> FAST.
  - FAST: dir == NONE or direction change -> IDLE (a direction change immediately re-enters SLOW on the next tick with dir != NONE). Otherwise stay FAST.
- Move, step S per state; use a 13-bit intermediate for the DN compare:
  - UP: if v1 >= S then v1 -= S, else v1 = 0.
  - DN: if v2 + S <= V_ACTIVE-1 then v2 += S, else v2 = V_ACTIVE-1.
  - v2 = v1 + H always; the other edge is recomputed in the same cycle.
- Outputs are registered; positions become visible 1 cycle after frame_tick.
- Reset mid-frame or mid-debounce: everything returns to its reset values immediately. No partial move is retained.
- Parameter legality: 0 <= RC_V1 < RC_V2 <= V_ACTIVE-1, STEP_FAST >= STEP_SLOW >= 1, HOLD_FRAMES >= 1. Violations are a synthesis assertion.

Decomposition:
- Package pong_pkg holds:
  - typedef coord_t (logic [11:0])
  - typedef enum paddle_state_t {IDLE, SLOW, FAST}
  - typedef enum dir_t {NONE, UP, DN}
  - constants H_ACTIVE = 1920, V_ACTIVE = 1080
- One sub-module, btn_debounce (synchroniser + debounce counter, DEBOUNCE_CYC parameter), instantiated twice.

Test Plan (DEBOUNCE_CYC = 16, HOLD_FRAMES = 3, reduced frame via h_count/v_count driver):
- Reset released -> v1 = 0, v2 = 250, h1 = 100, h2 = 200, fast = 0, btn_*_db = 0.
- btn_up pulse of 10 cycles -> btn_up_db stays 0; no move. btn_up held for 20 cycles -> btn_up_db = 1 exactly 2 + 16 cycles after the edge.
- Start at v1 = 100, btn_dn held -> per tick v1 goes 104, 108, 112, then FAST with fast = 1, then 124, 136; updates occur only on the cycle after v_count == 1080 && h_count == 0.
- Paddle at v2 = 1075, dn held in FAST -> v2 = 1079, v1 = 829; next tick unchanged. Paddle at v1 = 3, up in SLOW -> v1 = 0, v2 = 250.
- Both buttons held -> position frozen, FSM = IDLE. Up-to-down reversal while FAST -> the next tick moves by 4, not 12.
- rst asserted mid-FAST between ticks -> outputs return to reset values asynchronously, before the next clk edge.
